// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the KGP-RISC register file, decoder and ALU.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_ADDR_W);

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every entry once, emitting a zero-write per cycle.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // All-ones is DEPTH-1; compared explicitly so termination never relies on wrap.
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_busy = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, optional zero register,
// debug tap of one register and a sequential clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int TAP_REG     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic [DATA_W-1:0]        tap_data
);

  localparam int                DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] TAP_ADDR = ADDR_W'(TAP_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User writes are blocked while clearing and dropped when aimed at the zero register.
  assign usr_we = wr_en && !clr_busy && !((ZERO_REG_EN != 0) && (wr_addr == '0));

  // Value a read port registers this cycle: forced zero while clearing or for r0,
  // otherwise the in-flight write wins over the stored entry.
  function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] a);
    if (clr_busy) begin
      return '0;
    end
    if ((ZERO_REG_EN != 0) && (a == '0)) begin
      return '0;
    end
    if (usr_we && (wr_addr == a)) begin
      return wr_data;
    end
    return mem_q[a];
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (usr_we) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    always_comb begin
      rd_d = read_entry(rd_addr[k*ADDR_W +: ADDR_W]);
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
  end

  logic [DATA_W-1:0] tap_d;
  logic [DATA_W-1:0] tap_q;

  always_comb begin
    tap_d = read_entry(TAP_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tap_data = tap_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural array model;
// instance A has the zero register, instance B does not.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;

  logic [63:0] rd_data_a, rd_data_b;
  logic [31:0] tap_a, tap_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.ZERO_REG_EN(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(busy_a), .tap_data(tap_a)
  );

  regfile_mp #(.ZERO_REG_EN(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(busy_b), .tap_data(tap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 models instance A (zero reg), index 1 instance B.
  logic [31:0] mm [2][32];
  logic [31:0] exp_rd [2][2];
  logic [31:0] exp_tap [2];
  bit          m_busy;
  int          m_left;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] model_read(input int m, input logic [4:0] a);
    if (m == 0 && a == 5'd0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mm[m][a];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < 32; i++) mm[m][i] = 32'h0;
          exp_rd[m][0] = 32'h0;
          exp_rd[m][1] = 32'h0;
          exp_tap[m]   = 32'h0;
        end
        m_busy  = 1'b0;
        m_left  = 0;
        m_valid = 1'b1;
      end else if (m_busy) begin
        // Clear sweeps from entry 0 upward, one entry per cycle; reads see zero.
        for (int m = 0; m < 2; m++) begin
          mm[m][32 - m_left] = 32'h0;
          exp_rd[m][0] = 32'h0;
          exp_rd[m][1] = 32'h0;
          exp_tap[m]   = 32'h0;
        end
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          exp_rd[m][0] = model_read(m, rd_addr[4:0]);
          exp_rd[m][1] = model_read(m, rd_addr[9:5]);
          exp_tap[m]   = model_read(m, 5'd2);
          if (wr_en && !(m == 0 && wr_addr == 5'd0)) mm[m][wr_addr] = wr_data;
        end
        if (clr_req) begin
          m_busy = 1'b1;
          m_left = 32;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("a_rd0", rd_data_a[31:0],  exp_rd[0][0]);
        chk("a_rd1", rd_data_a[63:32], exp_rd[0][1]);
        chk("a_tap", tap_a,            exp_tap[0]);
        chk("a_busy", {31'h0, busy_a}, {31'h0, m_busy});
        chk("b_rd0", rd_data_b[31:0],  exp_rd[1][0]);
        chk("b_rd1", rd_data_b[63:32], exp_rd[1][1]);
        chk("b_tap", tap_b,            exp_tap[1]);
        chk("b_busy", {31'h0, busy_b}, {31'h0, m_busy});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  // Counts cycles with busy high; an overrun is reported as a failure.
  task automatic count_busy(input int lost_write_at, output int n);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      if (n == lost_write_at) wr(5'd9, 32'h55);
      step();
      wr_en = 1'b0;
    end
  endtask

  int n;

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    step();
    step();

    // Reset wipes a previously written register.
    reset = 1'b1;
    wr(5'd7, 32'hDEADBEEF);
    step();
    wr_en = 1'b0;
    reset = 1'b0;
    rd_addr[4:0] = 5'd7;
    step();
    step();
    reset = 1'b1;
    step();
    chk("reset_r7", rd_data_a[31:0], 32'h0);
    chk("reset_busy", {31'h0, busy_a}, 32'h0);
    chk("reset_tap", tap_a, 32'h0);

    // Same-cycle bypass, then a normal read.
    wr(5'd5, 32'h1234_5678);
    rd_addr = {5'd5, 5'd0};
    step();
    chk("bypass_p1", rd_data_a[63:32], 32'h1234_5678);
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd5};
    step();
    chk("read_p0_r5", rd_data_a[31:0], 32'h1234_5678);

    // Zero register with and without ZERO_REG_EN.
    wr(5'd0, 32'hFFFF_FFFF);
    rd_addr = {5'd0, 5'd0};
    step();
    chk("zero_bypass_a", rd_data_a[31:0], 32'h0);
    chk("zero_bypass_b", rd_data_b[31:0], 32'hFFFF_FFFF);
    wr_en = 1'b0;
    step();
    chk("zero_later_a", rd_data_a[63:32], 32'h0);
    chk("zero_later_b", rd_data_b[63:32], 32'hFFFF_FFFF);

    // Tap follows r2 only.
    wr(5'd2, 32'hA5A5_A5A5);
    step();
    chk("tap_r2", tap_a, 32'hA5A5_A5A5);
    wr(5'd3, 32'h0000_0077);
    step();
    chk("tap_r3_nochg", tap_a, 32'hA5A5_A5A5);
    wr_en = 1'b0;

    // Fill, clear, lost write during clear, then everything reads zero.
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 32'(i + 1));
      step();
    end
    wr_en = 1'b0;
    rd_addr = {5'd9, 5'd31};
    step();
    chk("fill_r31", rd_data_a[31:0], 32'd32);
    chk("fill_r9", rd_data_a[63:32], 32'd10);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    count_busy(5, n);
    chk("clr_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      step();
      chk("after_clr_p0", rd_data_a[31:0], 32'h0);
      chk("after_clr_p1", rd_data_b[63:32], 32'h0);
    end

    // Reset during clear aborts it; a fresh request runs the full length.
    wr(5'd4, 32'h44);
    step();
    wr_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b0;
    step();
    chk("abort_busy", {31'h0, busy_a}, 32'h0);
    reset = 1'b1;
    rd_addr = {5'd4, 5'd4};
    step();
    chk("abort_r4", rd_data_b[31:0], 32'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    count_busy(0, n);
    chk("restart_len", 32'(n), 32'd32);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) != 0);
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      clr_req = ($urandom_range(0, 149) == 0);
      rd_addr = ($urandom_range(0, 3) == 0) ? {wr_addr, wr_addr} : 10'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
